// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one factorial unit between two requesters.
// Optional watchdog in WAIT: define FACT_SCHED_TIMEOUT_EN.
module fact_sched #(
   parameter int N_W     = 4,
   parameter int RES_W   = 32,
   parameter int MAX_N   = 12,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [N_W-1:0]   n0,
   input  logic [N_W-1:0]   n1,
   output logic             ack0,
   output logic             ack1,
   output logic [RES_W-1:0] result,
   output logic             err,
   output logic             f_go,
   output logic [N_W-1:0]   f_n,
   input  logic             f_done,
   input  logic [RES_W-1:0] f_result
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic               owner_q, owner_d;
   logic               last_q, last_d;
   logic [N_W-1:0]     f_n_q, f_n_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic               err_q, err_d;
   logic               gnt;
   logic [N_W-1:0]     n_sel;

`ifdef FACT_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      f_n_d    = f_n_q;
      result_d = result_q;
      err_d    = err_q;
`ifdef FACT_SCHED_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      // On a tie the requester not granted last wins.
      gnt   = (req0 && req1) ? ~last_q : req1;
      n_sel = gnt ? n1 : n0;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               owner_d = gnt;
               f_n_d   = n_sel;
               if (n_sel > N_W'(MAX_N)) begin
                  result_d = '0;
                  err_d    = 1'b1;
                  state_d  = S_RESP;
               end else begin
                  state_d  = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT;
`ifdef FACT_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
`ifdef FACT_SCHED_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (f_done) begin
               result_d = f_result;
               err_d    = 1'b0;
               state_d  = S_RESP;
            end
`ifdef FACT_SCHED_TIMEOUT_EN
            else if (cnt_d == CNT_W'(TIMEOUT)) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = S_RESP;
            end
`endif
         end
         S_RESP: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         f_n_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
`ifdef FACT_SCHED_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         f_n_q    <= f_n_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef FACT_SCHED_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign f_go   = (state_q == S_LAUNCH);
   assign ack0   = (state_q == S_RESP) && !owner_q;
   assign ack1   = (state_q == S_RESP) &&  owner_q;
   assign f_n    = f_n_q;
   assign result = result_q;
   assign err    = err_q;

endmodule

// File: doc/fact_sched.md
# fact_sched

Round-robin scheduler that shares one factorial datapath/control pair between two requesters, for example the processor's memory-mapped port and the GPIO front end.
- Per requester: accepts an operand, range-checks it, launches the unit with a one-cycle go pulse, waits for done, then returns the result with a one-cycle acknowledge.
- Sits between the requesters and the factorial unit's go/done/result pins; the factorial unit itself is unchanged.

## Interface
- N_W, 4: operand width.
- RES_W, 32: result width.
- MAX_N, 12: largest legal operand; above this the result overflows RES_W.
- TIMEOUT, 255: WAIT-state cycle limit (only with the watchdog compiled in).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  request level; held high until the matching ack.
- n0 / n1  in  N_W  operand; stable while req is high.
- ack0 / ack1  out  1  one-cycle pulse; result and err are valid in the same cycle.
- result  out  RES_W  shared result bus.
- err  out  1  range or timeout error for the acked transaction.
- f_go  out  1  one-cycle start pulse to the factorial unit.
- f_n  out  N_W  operand to the factorial unit; held from LAUNCH through WAIT.
- f_done  in  1  completion pulse from the factorial unit.
- f_result  in  RES_W  factorial unit result; valid when f_done is high.

## Operation
States:
- IDLE: if no request, stay.
  - Otherwise grant by round-robin: the requester not granted last wins a tie. After reset, requester 0 wins.
  - Latch owner and operand.
  - If operand > MAX_N, go to RESP with err=1 and result=0. Otherwise go to LAUNCH.
- LAUNCH: f_go=1 for exactly one cycle. Go to WAIT and clear the watchdog counter.
- WAIT: on f_done, capture f_result into result, set err=0, go to RESP.
  - Watchdog compiled in: when the counter reaches TIMEOUT, set err=1 and result=0, go to RESP.
- RESP: ack of the owner = 1 for one cycle. Update the last-grant pointer to the owner. Go to IDLE.

Rules:
- result and err hold their values until the next RESP overwrites them.
- f_done is ignored outside WAIT.
- Requester protocol: deassert req in the cycle after the ack. A req still high in IDLE is a new request.
- If req drops before ack, the transaction still completes and the ack is still pulsed. The scheduler never aborts the datapath.
- The scheduler never issues f_go while an operation is outstanding.
- Operand 0 and 1 are legal; the factorial unit defines their result.

## Timing
- Reset values: state=IDLE, ack0=ack1=0, f_go=0, f_n=0, result=0, err=0, last-grant pointer=1 (so requester 0 wins first).
- All outputs are decoded from registered state and registered data; there are no combinational input-to-output paths.
- Latency:
  - req high sampled in IDLE at edge k: f_go high in cycle k+1.
  - f_done sampled at edge m: ack high in cycle m+1.
  - Range error: ack in cycle k+1, no f_go.
- Minimum spacing between grants: RESP→IDLE→LAUNCH, so one IDLE cycle between transactions.
- Reset asserted mid-operation: everything returns to reset values immediately, and no ack is issued for the lost transaction. The factorial unit must be reset by the same rst_n source.

## Configuration
- FACT_SCHED_TIMEOUT_EN defined: an 8-bit (clog2(TIMEOUT+1)) watchdog counter runs in WAIT. Reaching TIMEOUT forces RESP with err=1 and result=0.
- Not defined: no counter logic; WAIT waits for f_done indefinitely. err is then driven only by the range check.

## Test plan
- Single request: req0=1, n0=5; model returns 120 after 20 cycles → f_go pulse 1 cycle after req, f_n=5, ack0 with result=120 and err=0 one cycle after f_done. ack1 stays 0.
- Simultaneous: req0 and req1 high together, n0=3, n1=4 after reset → requester 0 served first (result=6, ack0), then requester 1 (result=24, ack1). Only one f_go outstanding at a time.
- Fairness: req0 held continuously and reasserted after each ack while req1 pending → grants alternate 0,1,0,1.
- Range error: n1=13 → ack1 one cycle after grant with err=1 and result=0; f_go never asserted.
- Timeout (macro defined): model never raises f_done → ack with err=1 and result=0 exactly TIMEOUT cycles after entering WAIT. A later f_done pulse is ignored.
- Reset mid-WAIT: drop rst_n while in WAIT → all outputs return to 0 asynchronously. After release, a new req0 with n0=4 returns 24 with a correct ack.
